alu_sequencer: RTL and testbench

- Multi-cycle control unit that sequences the 16x8 register-file/ALU datapath.
- Fetches 20-bit instructions from an instruction memory over a req/valid handshake and decodes them into register addresses, immediate, ALUSrc, ALUControl and write_enable.
- Resolves BEQ/BNE from the datapath Zero flag and maintains the PC, halt state and a retired-instruction count.
- Sits between the instruction ROM and the register-file/ALU datapath; together they form the processor core.

---
 rtl/alu_seq_pkg.sv | 62 ++++++
 rtl/alu_seq_decode.sv | 72 +++++++
 rtl/alu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, FSM states,
// instruction field positions, ALUControl encodings and the decoded control bundle.
package alu_seq_pkg;

    localparam int unsigned INSTR_W = 20;

    // Instruction field bit positions: op[19:16] f1[15:12] f2[11:8] imm[7:0]
    localparam int unsigned OP_MSB  = 19;
    localparam int unsigned OP_LSB  = 16;
    localparam int unsigned F1_MSB  = 15;
    localparam int unsigned F1_LSB  = 12;
    localparam int unsigned F2_MSB  = 11;
    localparam int unsigned F2_LSB  = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 0;

    // ALUControl encodings seen by the datapath
    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [3:0] {
        OP_AND   = 4'h0,
        OP_OR    = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_ANDI  = 4'h4,
        OP_ORI   = 4'h5,
        OP_ADDI  = 4'h6,
        OP_SUBI  = 4'h7,
        OP_BEQ   = 4'h8,
        OP_BNE   = 4'h9,
        OP_JMP   = 4'hA,
        OP_NOP_B = 4'hB,
        OP_NOP_C = 4'hC,
        OP_NOP_D = 4'hD,
        OP_NOP_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Datapath-facing control bundle produced by the decoder
    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa;
        logic [7:0] imm;
        logic       alu_src;
        logic [1:0] alu_ctrl;
        logic       we;
    } ctrl_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: maps the latched instruction word onto
// register addresses, immediate, ALU controls and control-flow flags.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] ir_i,
    output ctrl_t              ctrl_o,
    output logic               is_branch_o,
    output logic               branch_ne_o,
    output logic               is_jmp_o,
    output logic               is_halt_o
);

    logic [3:0] op_bits;
    logic [3:0] f1;
    logic [3:0] f2;
    logic [7:0] imm;
    logic [3:0] rs2;
    opcode_e    op;

    assign op_bits = ir_i[OP_MSB:OP_LSB];
    assign f1      = ir_i[F1_MSB:F1_LSB];
    assign f2      = ir_i[F2_MSB:F2_LSB];
    assign imm     = ir_i[IMM_MSB:IMM_LSB];
    assign rs2     = imm[RS2_MSB:RS2_LSB];
    assign op      = opcode_e'(op_bits);

    // Decode the opcode; unused fields stay at zero for every instruction class
    always_comb begin
        ctrl_o      = '0;
        is_branch_o = 1'b0;
        branch_ne_o = 1'b0;
        is_jmp_o    = 1'b0;
        is_halt_o   = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: begin
                ctrl_o.wa       = f1;
                ctrl_o.ra1      = f2;
                ctrl_o.ra2      = rs2;
                ctrl_o.alu_src  = 1'b0;
                ctrl_o.alu_ctrl = op_bits[1:0];
                ctrl_o.we       = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_ADDI, OP_SUBI: begin
                ctrl_o.wa       = f1;
                ctrl_o.ra1      = f2;
                ctrl_o.imm      = imm;
                ctrl_o.alu_src  = 1'b1;
                ctrl_o.alu_ctrl = op_bits[1:0];
                ctrl_o.we       = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                // Compare by subtraction; the datapath reports equality on Zero
                ctrl_o.ra1      = f2;
                ctrl_o.ra2      = f1;
                ctrl_o.alu_src  = 1'b0;
                ctrl_o.alu_ctrl = ALU_SUB;
                is_branch_o     = 1'b1;
                branch_ne_o     = (op == OP_BNE);
            end
            OP_JMP: begin
                is_jmp_o = 1'b1;
            end
            OP_HALT: begin
                is_halt_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the register-file/ALU datapath: fetches over a
// req/valid handshake, executes each instruction in one EXEC cycle, and keeps
// the PC, halt state and a saturating retired-instruction count.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               Zero,
    output logic [3:0]         RA1,
    output logic [3:0]         RA2,
    output logic [3:0]         WA,
    output logic [7:0]         immediate,
    output logic               ALUSrc,
    output logic [1:0]         ALUControl,
    output logic               write_enable,
    output logic               busy,
    output logic               halted,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   retired
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic                 imem_req_q;
    logic                 busy_q;
    logic                 halted_q;

    ctrl_t                dec_ctrl;
    ctrl_t                out_ctrl;
    logic                 dec_is_branch;
    logic                 dec_branch_ne;
    logic                 dec_is_jmp;
    logic                 dec_is_halt;

    logic [7:0]           imm_field;
    logic signed [7:0]    imm_signed;
    logic [PC_W-1:0]      pc_seq;
    logic [PC_W-1:0]      pc_branch;
    logic [PC_W-1:0]      pc_jump;
    logic                 branch_taken;
    logic [CNT_W-1:0]     retired_inc;

    alu_seq_decode u_decode (
        .ir_i        (ir_q),
        .ctrl_o      (dec_ctrl),
        .is_branch_o (dec_is_branch),
        .branch_ne_o (dec_branch_ne),
        .is_jmp_o    (dec_is_jmp),
        .is_halt_o   (dec_is_halt)
    );

    // Control-flow targets; all PC arithmetic wraps modulo 2^PC_W
    assign imm_field    = ir_q[IMM_MSB:IMM_LSB];
    assign imm_signed   = imm_field;
    assign pc_seq       = pc_q + PC_W'(1);
    assign pc_branch    = pc_q + PC_W'(imm_signed);
    assign pc_jump      = PC_W'(imm_field);
    assign branch_taken = dec_is_branch & (Zero ^ dec_branch_ne);
    assign retired_inc  = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);

    // Next-state, PC, IR and counter selection
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                retired_d = retired_inc;
                if (dec_is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    if (branch_taken) begin
                        pc_d = pc_branch;
                    end else if (dec_is_jmp) begin
                        pc_d = pc_jump;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, architectural registers and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            retired_q  <= '0;
            imem_req_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            retired_q  <= retired_d;
            imem_req_q <= (state_d == ST_FETCH);
            busy_q     <= (state_d == ST_FETCH) || (state_d == ST_EXEC);
            halted_q   <= (state_d == ST_HALT);
        end
    end

    // Datapath controls are live only during EXEC, zero otherwise
    always_comb begin
        out_ctrl = '0;
        if (state_q == ST_EXEC) begin
            out_ctrl = dec_ctrl;
        end
    end

    assign RA1          = out_ctrl.ra1;
    assign RA2          = out_ctrl.ra2;
    assign WA           = out_ctrl.wa;
    assign immediate    = out_ctrl.imm;
    assign ALUSrc       = out_ctrl.alu_src;
    assign ALUControl   = out_ctrl.alu_ctrl;
    assign write_enable = out_ctrl.we;

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with an instruction ROM and a
// small register-file/ALU datapath model.
module tb_alu_sequencer;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned CNT_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_valid;
    logic [19:0]       imem_rdata;
    logic              Zero;
    logic [3:0]        RA1;
    logic [3:0]        RA2;
    logic [3:0]        WA;
    logic [7:0]        immediate;
    logic              ALUSrc;
    logic [1:0]        ALUControl;
    logic              write_enable;
    logic              busy;
    logic              halted;
    logic [PC_W-1:0]   pc;
    logic [CNT_W-1:0]  retired;

    logic [19:0]       rom [256];
    logic              auto_mode;
    logic              man_valid;
    logic [19:0]       man_rdata;
    logic [7:0]        rf [16];
    logic [7:0]        opa;
    logic [7:0]        opb;
    logic [7:0]        alu_res;
    int unsigned       we_count = 0;
    int unsigned       we_base;
    int                checks = 0;
    int                failures = 0;

    alu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .Zero         (Zero),
        .RA1          (RA1),
        .RA2          (RA2),
        .WA           (WA),
        .immediate    (immediate),
        .ALUSrc       (ALUSrc),
        .ALUControl   (ALUControl),
        .write_enable (write_enable),
        .busy         (busy),
        .halted       (halted),
        .pc           (pc),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    // Instruction memory: zero-wait ROM in auto mode, hand-driven otherwise
    assign imem_valid = auto_mode ? imem_req : man_valid;
    assign imem_rdata = auto_mode ? rom[imem_addr] : man_rdata;

    // Datapath ALU model
    always_comb begin
        opa = rf[RA1];
        opb = ALUSrc ? immediate : rf[RA2];
        case (ALUControl)
            2'b00:   alu_res = opa & opb;
            2'b01:   alu_res = opa | opb;
            2'b10:   alu_res = opa + opb;
            default: alu_res = opa - opb;
        endcase
    end
    assign Zero = (alu_res == 8'h00);

    // Register file model; r0 stays zero
    always @(posedge clk) begin
        if (write_enable) we_count <= we_count + 1;
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (write_enable && WA != 4'd0) begin
            rf[WA] <= alu_res;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (halted !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic run_branch(input string tag, input logic [7:0] r2val,
                              input logic [3:0] op, input logic [7:0] exp_addr);
        int n = 0;
        auto_mode = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        rom[0] = 20'h61007;
        rom[1] = {4'h6, 4'h2, 4'h0, r2val};
        rom[2] = 20'hB0000;
        rom[3] = 20'hB0000;
        rom[4] = {op, 4'h2, 4'h1, 8'hFE};
        rom[5] = 20'hF0000;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!(busy === 1'b1 && imem_req === 1'b0 && pc === 8'd4) && n < 40) begin
            step();
            n++;
        end
        check({tag, "_ra1"}, RA1, 4'd1);
        check({tag, "_ra2"}, RA2, 4'd2);
        check({tag, "_we"}, write_enable, 1'b0);
        check({tag, "_ctrl"}, ALUControl, 2'b11);
        step();
        check({tag, "_addr"}, imem_addr, exp_addr);
        check({tag, "_req"}, imem_req, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        auto_mode = 1'b1;
        man_valid = 1'b0;
        man_rdata = 20'h00000;
        for (int i = 0; i < 256; i++) rom[i] = 20'hF0000;
        step();
        step();

        // Reset state
        check("rst_pc", pc, 0);
        check("rst_retired", retired, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_req", imem_req, 0);
        check("rst_we", write_enable, 0);

        // Program: ADDI r1,r0,5; ADDI r2,r0,3; SUB r3,r1,r2; HALT
        rom[0] = 20'h61005;
        rom[1] = 20'h62003;
        rom[2] = 20'h33102;
        rom[3] = 20'hF0000;
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("p1_fetch_busy", busy, 1);
        check("p1_fetch_req", imem_req, 1);
        check("p1_fetch_addr", imem_addr, 0);
        we_base = we_count;
        step();
        check("p1_exec_we", write_enable, 1);
        check("p1_exec_wa", WA, 1);
        check("p1_exec_ra1", RA1, 0);
        check("p1_exec_imm", immediate, 5);
        check("p1_exec_alusrc", ALUSrc, 1);
        check("p1_exec_ctrl", ALUControl, 2'b10);
        wait_halt("p1_halted");
        check("p1_r3", rf[3], 8'd2);
        check("p1_retired", retired, 4);
        check("p1_pc", pc, 3);
        check("p1_busy", busy, 0);
        check("p1_we_pulses", we_count - we_base, 3);

        // HALT then start: pc and retired clear, fetch restarts at 0
        start = 1'b1;
        step();
        start = 1'b0;
        check("rs_pc", pc, 0);
        check("rs_retired", retired, 0);
        check("rs_addr", imem_addr, 0);
        check("rs_req", imem_req, 1);
        check("rs_halted", halted, 0);
        wait_halt("rs_halted2");
        check("rs_retired2", retired, 4);

        // Branch resolution
        run_branch("beq_taken", 8'd7, 4'h8, 8'd2);
        run_branch("beq_not", 8'd6, 4'h8, 8'd5);
        run_branch("bne_taken", 8'd6, 4'h9, 8'd2);
        run_branch("bne_not", 8'd7, 4'h9, 8'd5);

        // Delayed imem_valid: hold request, capture only on the valid cycle
        reset = 1'b1;
        step();
        reset = 1'b0;
        auto_mode = 1'b0;
        man_valid = 1'b0;
        man_rdata = 20'hF0000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("dly_req", imem_req, 1);
            check("dly_addr", imem_addr, 0);
            check("dly_busy", busy, 1);
            check("dly_we", write_enable, 0);
            check("dly_wa", WA, 0);
            step();
        end
        man_rdata = 20'h65009;
        man_valid = 1'b1;
        step();
        man_rdata = 20'hF0000;
        check("dly_exec_we", write_enable, 1);
        check("dly_exec_wa", WA, 5);
        check("dly_exec_imm", immediate, 9);
        check("dly_exec_req", imem_req, 0);
        // valid still high during EXEC must be ignored
        step();
        man_valid = 1'b0;
        check("dly_next_addr", imem_addr, 1);
        check("dly_next_req", imem_req, 1);

        // Reset during EXEC of ADD r6,r1,r2
        man_rdata = 20'h26102;
        man_valid = 1'b1;
        step();
        man_valid = 1'b0;
        check("rx_exec_we", write_enable, 1);
        check("rx_exec_wa", WA, 6);
        check("rx_exec_ctrl", ALUControl, 2'b10);
        check("rx_pre_retired", retired, 1);
        reset = 1'b1;
        step();
        check("rx_we", write_enable, 0);
        check("rx_busy", busy, 0);
        check("rx_pc", pc, 0);
        check("rx_retired", retired, 0);
        check("rx_req", imem_req, 0);
        reset = 1'b0;

        // Stray imem_valid in IDLE is ignored
        man_rdata = 20'h61005;
        man_valid = 1'b1;
        step();
        step();
        man_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_req", imem_req, 0);
        check("idle_wa", WA, 0);

        // start held during FETCH has no effect
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        check("sf_req", imem_req, 1);
        check("sf_addr", imem_addr, 0);
        check("sf_busy", busy, 1);
        man_rdata = 20'hF0000;
        man_valid = 1'b1;
        step();
        man_valid = 1'b0;
        step();
        check("sf_halted", halted, 1);
        check("sf_pc", pc, 0);
        check("sf_retired", retired, 1);

        // JMP 0xFF then ADDI at 255 wraps pc to 0
        auto_mode = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        rom[0] = 20'hA00FF;
        rom[255] = 20'h67001;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("jmp_pc", pc, 255);
        check("jmp_addr", imem_addr, 255);
        step();
        check("jmp_exec_we", write_enable, 1);
        check("jmp_exec_wa", WA, 7);
        step();
        check("wrap_pc", pc, 0);
        check("wrap_retired", retired, 2);

        // Retired counter saturates at all-ones
        for (int k = 0; k < 40; k++) step();
        check("sat_retired", retired, 15);
        check("sat_busy", busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
